mac_acumulador: RTL

- Datapath stage directly downstream of the sequencing controller (ControlMux).
- Each cycle it consumes the controller's selects (sel_const, sel_fun, sel_acum, Band_Listo) and multiplies the selected coefficient by the selected function sample in signed fixed point.
- It accumulates NUM_TERMS such terms and publishes one saturated result per evaluation, with a valid pulse and error flags.

---
 rtl/mac_acumulador.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mac_acumulador.sv
`default_nettype none
// ============================================================================
// Module   : mac_acumulador
// Purpose  : Signed fixed-point MAC that accumulates NUM_TERMS coefficient x
//            sample terms chosen by the controller and publishes a saturated
//            result with a valid pulse and sticky error flags.
// Revision : 1.0  initial release
// ============================================================================
module mac_acumulador #(
  parameter int                      WIDTH     = 16,
  parameter int                      FRAC      = 8,
  parameter int                      NUM_TERMS = 6,
  parameter logic signed [WIDTH-1:0] C0        = WIDTH'(256),
  parameter logic signed [WIDTH-1:0] C1        = WIDTH'(128),
  parameter logic signed [WIDTH-1:0] C2        = WIDTH'(64),
  parameter logic signed [WIDTH-1:0] C3        = WIDTH'(256),
  parameter logic signed [WIDTH-1:0] C4        = WIDTH'(128),
  parameter logic signed [WIDTH-1:0] C5        = WIDTH'(64)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    Bandera,
  input  logic [2:0]              sel_const,
  input  logic [1:0]              sel_fun,
  input  logic                    sel_acum,
  input  logic                    Band_Listo,
  input  logic signed [WIDTH-1:0] fun0,
  input  logic signed [WIDTH-1:0] fun1,
  input  logic signed [WIDTH-1:0] fun2,
  output logic signed [WIDTH-1:0] resultado,
  output logic                    valido,
  output logic                    overflow,
  output logic                    err_seq
);

  localparam int PW = 2*WIDTH + 1;
  localparam int AW = WIDTH + 3;
  localparam int CW = $clog2(NUM_TERMS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACUM  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic signed [PW-1:0]    c_half  = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0]    c_pmax  = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0]    c_pmin  = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [AW-1:0]    c_amax  = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0]    c_amin  = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] c_wmax  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] c_wmin  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]           c_last  = CW'(NUM_TERMS - 1);

  logic [2:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic signed [WIDTH-1:0] r_prod;
  logic                    r_ld;
  logic                    r_add;
  logic signed [AW-1:0]    r_acc;
  logic signed [WIDTH-1:0] r_result;
  logic                    r_valido;
  logic                    r_ovf;
  logic                    r_err;

  logic signed [WIDTH-1:0] w_coef;
  logic signed [WIDTH-1:0] w_fun;
  logic signed [PW-1:0]    w_coef_x;
  logic signed [PW-1:0]    w_fun_x;
  logic signed [PW-1:0]    w_prod_rnd;
  logic signed [PW-1:0]    w_prod_shr;
  logic signed [WIDTH-1:0] w_prod_sat;
  logic                    w_prod_ovf;
  logic signed [AW-1:0]    w_acc_base;
  logic signed [AW-1:0]    w_acc_next;
  logic signed [WIDTH-1:0] w_acc_sat;
  logic                    w_acc_ovf;

  always_comb begin
    case (sel_const)
      3'd0:    w_coef = C0;
      3'd1:    w_coef = C1;
      3'd2:    w_coef = C2;
      3'd3:    w_coef = C3;
      3'd4:    w_coef = C4;
      3'd5:    w_coef = C5;
      default: w_coef = '0;
    endcase
    case (sel_fun)
      2'd0:    w_fun = fun0;
      2'd1:    w_fun = fun1;
      2'd2:    w_fun = fun2;
      default: w_fun = '0;
    endcase
  end

  // Round half up, then arithmetic shift back to the shared Q format
  assign w_coef_x   = $signed({{(PW-WIDTH){w_coef[WIDTH-1]}}, w_coef});
  assign w_fun_x    = $signed({{(PW-WIDTH){w_fun[WIDTH-1]}}, w_fun});
  assign w_prod_rnd = (w_coef_x * w_fun_x) + c_half;
  assign w_prod_shr = w_prod_rnd >>> FRAC;

  always_comb begin
    w_prod_ovf = 1'b0;
    w_prod_sat = w_prod_shr[WIDTH-1:0];
    if (w_prod_shr > c_pmax) begin
      w_prod_sat = c_wmax;
      w_prod_ovf = 1'b1;
    end else if (w_prod_shr < c_pmin) begin
      w_prod_sat = c_wmin;
      w_prod_ovf = 1'b1;
    end
  end

  assign w_acc_base = r_ld ? '0 : r_acc;
  assign w_acc_next = w_acc_base + $signed({{(AW-WIDTH){r_prod[WIDTH-1]}}, r_prod});

  always_comb begin
    w_acc_ovf = 1'b0;
    w_acc_sat = r_acc[WIDTH-1:0];
    if (r_acc > c_amax) begin
      w_acc_sat = c_wmax;
      w_acc_ovf = 1'b1;
    end else if (r_acc < c_amin) begin
      w_acc_sat = c_wmin;
      w_acc_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_ld     <= 1'b0;
      r_add    <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_valido <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else if (Bandera) begin
      // Restart keeps the last published result visible
      r_state  <= S_ACUM;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_ld     <= 1'b0;
      r_add    <= 1'b0;
      r_acc    <= '0;
      r_valido <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valido <= 1'b0;
      r_add    <= 1'b0;
      if (r_add) begin
        r_acc <= w_acc_next;
      end
      case (r_state)
        S_ACUM: begin
          r_prod <= w_prod_sat;
          r_ld   <= ~sel_acum;
          r_add  <= 1'b1;
          r_cnt  <= r_cnt + 1'b1;
          if (w_prod_ovf) r_ovf <= 1'b1;
          if (Band_Listo) r_err <= 1'b1;
          if (r_cnt == c_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (Band_Listo) r_err <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (Band_Listo) begin
            r_result <= w_acc_sat;
            r_valido <= 1'b1;
            if (w_acc_ovf) r_ovf <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign resultado = r_result;
  assign valido    = r_valido;
  assign overflow  = r_ovf;
  assign err_seq   = r_err;

endmodule
`default_nettype wire
